// File: rtl/prep_prescale_timer_pkg.sv
// rtl/prep_prescale_timer_pkg.sv - shared types and constants for the prescale timer
package prep_prescale_timer_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/prep_prescale_timer.sv
// rtl/prep_prescale_timer.sv - reloadable down-counting prescaler emitting a one-cycle TC strobe
module prep_prescale_timer
  import prep_prescale_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             EN_IN,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] start_val;

  // Next-state for reload register, counter, FSM and registered strobes
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    r_d     = LD ? D : r_q;
    // A START in the same cycle as LD takes D directly so the new value is not a cycle late
    start_val = LD ? D : r_q;

    if (STOP) begin
      state_d = IDLE;
    end else if (START) begin
      // Restart wins over a pending zero, so no TC is produced here
      state_d = RUN;
      q_d     = start_val;
    end else if (state_q == RUN && EN_IN) begin
      if (q_q != '0) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (MODE == PERIODIC) begin
          // Auto-reload uses the register value; an LD this cycle applies from the next reload
          q_d = r_q;
        end else begin
          state_d = IDLE;
          q_d     = '0;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign Q    = q_q;
  assign TC   = tc_q;
  assign BUSY = busy_q;

endmodule
